// File: rtl/phase_sweep_ctrl_if.sv
//==============================================================================
// phase_sweep_ctrl_if : control/status bundle between host and phase sweep ctrl
// Revision: 1.0
//==============================================================================
`default_nettype none

interface phase_sweep_ctrl_if #(
  parameter int NB_BER = 64,
  parameter int NB_WIN = 32
);
  logic              i_start;
  logic              i_abort;
  logic [NB_WIN-1:0] i_window;
  logic [NB_BER-1:0] i_error_count_I;
  logic [NB_BER-1:0] i_error_count_Q;
  logic              o_enb_tx;
  logic              o_enb_rx;
  logic              o_reset_ber;
  logic [1:0]        o_phase_sel;
  logic              o_busy;
  logic              o_done;
  logic              o_valid;
  logic [1:0]        o_best_phase;
  logic [NB_BER:0]   o_best_errors;
  logic              o_lock;

  modport master (
    output i_start, i_abort, i_window, i_error_count_I, i_error_count_Q,
    input  o_enb_tx, o_enb_rx, o_reset_ber, o_phase_sel, o_busy, o_done,
           o_valid, o_best_phase, o_best_errors, o_lock
  );

  modport slave (
    input  i_start, i_abort, i_window, i_error_count_I, i_error_count_Q,
    output o_enb_tx, o_enb_rx, o_reset_ber, o_phase_sel, o_busy, o_done,
           o_valid, o_best_phase, o_best_errors, o_lock
  );
endinterface

`default_nettype wire

// File: rtl/phase_sweep_ctrl.sv
//==============================================================================
// phase_sweep_ctrl : sweeps the 4 RX sampling offsets, measures I+Q BER per
// offset and selects the offset with the fewest errors.
// Revision: 1.0
//==============================================================================
`default_nettype none

module phase_sweep_ctrl #(
  parameter int NB_BER = 64,
  parameter int NB_WIN = 32,
  parameter int SETTLE = 1024
) (
  input  wire logic          clock,
  input  wire logic          reset,
  phase_sweep_ctrl_if.slave  bus
);

  localparam int NB_SET = $clog2(SETTLE + 1);
  localparam int NB_CNT = (NB_WIN > NB_SET) ? NB_WIN : NB_SET;
  localparam logic [NB_CNT-1:0] SETTLE_LAST = NB_CNT'(SETTLE - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_CLR    = 3'd2;
  localparam logic [2:0] ST_MEAS   = 3'd3;
  localparam logic [2:0] ST_EVAL   = 3'd4;
  localparam logic [2:0] ST_FINAL  = 3'd5;

  logic [2:0]        state, state_nxt;
  logic [NB_CNT-1:0] cnt, cnt_nxt;
  logic [NB_CNT-1:0] meas_last, meas_last_nxt;
  logic [1:0]        phase, phase_nxt;
  logic [1:0]        best, best_nxt;
  logic [NB_BER:0]   min_err, min_err_nxt;
  logic [NB_BER:0]   sum;
  logic              result_ok, result_ok_nxt;
  logic              abort_go, start_go;

  logic              enb, enb_nxt;
  logic              reset_ber, reset_ber_nxt;
  logic [1:0]        phase_sel, phase_sel_nxt;
  logic              busy, busy_nxt;
  logic              done, done_nxt;
  logic              valid, valid_nxt;
  logic [1:0]        best_phase, best_phase_nxt;
  logic [NB_BER:0]   best_errors, best_errors_nxt;
  logic              lock, lock_nxt;

  assign abort_go = bus.i_abort && (state != ST_IDLE);
  assign start_go = (state == ST_IDLE) && bus.i_start && !bus.i_abort;
  assign sum      = {1'b0, bus.i_error_count_I} + {1'b0, bus.i_error_count_Q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      meas_last   <= '0;
      phase       <= 2'd0;
      best        <= 2'd0;
      min_err     <= '1;
      result_ok   <= 1'b0;
      enb         <= 1'b0;
      reset_ber   <= 1'b0;
      phase_sel   <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      valid       <= 1'b0;
      best_phase  <= 2'd0;
      best_errors <= '1;
      lock        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      meas_last   <= meas_last_nxt;
      phase       <= phase_nxt;
      best        <= best_nxt;
      min_err     <= min_err_nxt;
      result_ok   <= result_ok_nxt;
      enb         <= enb_nxt;
      reset_ber   <= reset_ber_nxt;
      phase_sel   <= phase_sel_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      valid       <= valid_nxt;
      best_phase  <= best_phase_nxt;
      best_errors <= best_errors_nxt;
      lock        <= lock_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort_go) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start_go) state_nxt = ST_SETTLE;
        ST_SETTLE: if (cnt == SETTLE_LAST) state_nxt = ST_CLR;
        ST_CLR:    state_nxt = ST_MEAS;
        ST_MEAS:   if (cnt == meas_last) state_nxt = ST_EVAL;
        ST_EVAL:   state_nxt = (phase == 2'd3) ? ST_FINAL : ST_SETTLE;
        ST_FINAL:  state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered: this block computes their values for the next state.
  always_comb begin
    cnt_nxt = ((state_nxt == state) && ((state == ST_SETTLE) || (state == ST_MEAS)))
              ? cnt + NB_CNT'(1) : '0;

    meas_last_nxt = meas_last;
    if (start_go)
      meas_last_nxt = (bus.i_window == '0) ? '0 : NB_CNT'(bus.i_window - NB_WIN'(1));

    phase_nxt   = phase;
    best_nxt    = best;
    min_err_nxt = min_err;
    if (start_go) begin
      phase_nxt   = 2'd0;
      best_nxt    = 2'd0;
      min_err_nxt = '1;
    end else if (state == ST_EVAL) begin
      if (sum < min_err) begin
        min_err_nxt = sum;
        best_nxt    = phase;
      end
      if (state_nxt == ST_SETTLE) phase_nxt = phase + 2'd1;
    end

    enb_nxt       = abort_go ? 1'b0 : ((state_nxt != ST_IDLE) ? 1'b1 : enb);
    busy_nxt      = (state_nxt == ST_SETTLE) || (state_nxt == ST_CLR) ||
                    (state_nxt == ST_MEAS)   || (state_nxt == ST_EVAL);
    reset_ber_nxt = (state_nxt == ST_CLR) || (state_nxt == ST_FINAL);
    done_nxt      = (state_nxt == ST_FINAL);
    result_ok_nxt = (state_nxt == ST_FINAL) ? 1'b1 : result_ok;

    phase_sel_nxt   = phase_nxt;
    valid_nxt       = valid;
    lock_nxt        = lock;
    best_phase_nxt  = best_phase;
    best_errors_nxt = best_errors;
    if (abort_go) begin
      // A stale result from an earlier completed sweep stays published.
      phase_sel_nxt = 2'd0;
      valid_nxt     = result_ok;
      lock_nxt      = result_ok && (best_errors == '0);
    end else if (start_go) begin
      valid_nxt = 1'b0;
      lock_nxt  = 1'b0;
    end else if (state_nxt == ST_FINAL) begin
      phase_sel_nxt   = best_nxt;
      valid_nxt       = 1'b1;
      lock_nxt        = (min_err_nxt == '0);
      best_phase_nxt  = best_nxt;
      best_errors_nxt = min_err_nxt;
    end else if (state_nxt == ST_IDLE) begin
      phase_sel_nxt = phase_sel;
    end
  end

  assign bus.o_enb_tx      = enb;
  assign bus.o_enb_rx      = enb;
  assign bus.o_reset_ber   = reset_ber;
  assign bus.o_phase_sel   = phase_sel;
  assign bus.o_busy        = busy;
  assign bus.o_done        = done;
  assign bus.o_valid       = valid;
  assign bus.o_best_phase  = best_phase;
  assign bus.o_best_errors = best_errors;
  assign bus.o_lock        = lock;

endmodule

`default_nettype wire
